spi_master_ctrl: RTL

SPI master that drives frames into the team's SPI slave register interface, the initiator end of the same link. It accepts a command (read or write, address, burst length), serialises start bit, R/W bit, address and data onto SS/MOSI, and collects read data from MISO. It sits between a local controller or test sequencer and the serial pins, sharing the slave's SCLK domain.

---
 rtl/spi_master_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   SPI master that sends frames to the SPI slave register interface.
//   Frame: SETUP (SS low, idle) -> start bit -> R/W bit -> address (MSB first)
//   -> write data bytes, or turnaround then read data bytes -> HOLD -> GAP.
//   The FSM runs on the rising edge of SCLK. SS and MOSI are re-launched on
//   the falling edge, which gives the slave half a cycle of setup time.
//
// Configuration macro:
//   SPI_MASTER_BURST_EN  defined:   Cmd_Len+1 data bytes per frame.
//                        undefined: exactly one data byte per frame, and
//                                   Cmd_Len is ignored.
//
// Ports:
//   SCLK, RST        clock; synchronous active-high reset
//   Cmd_Valid/Ready  command handshake (Cmd_Ready is high only in IDLE)
//   Cmd_RW           0 = write, 1 = read
//   Cmd_Addr         register address
//   Cmd_Len          burst length minus 1
//   Tx_Data          show-ahead write byte
//   Tx_Pop           pulse: Tx_Data loaded into the shifter
//   Rx_Data          last received byte
//   Rx_Valid         pulse: Rx_Data updated
//   Busy             frame in progress
//   Done             pulse in the last (GAP) cycle of a frame
//   SS, MOSI, MISO   serial pins (SS active low)
module spi_master_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned TURNAROUND   = 1,
  parameter int unsigned LEN_W        = 3
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic             Cmd_RW,
  input  logic [WIDTH-1:0] Cmd_Addr,
  input  logic [LEN_W-1:0] Cmd_Len,
  input  logic [WIDTH-1:0] Tx_Data,
  output logic             Tx_Pop,
  output logic [WIDTH-1:0] Rx_Data,
  output logic             Rx_Valid,
  output logic             Busy,
  output logic             Done,
  output logic             SS,
  output logic             MOSI,
  input  logic             MISO
);

  // A single counter serves the setup, address, turnaround and data-bit phases.
  localparam int unsigned CMAX0 = (WIDTH > SETUP_CYCLES) ? WIDTH : SETUP_CYCLES;
  localparam int unsigned CMAX  = (CMAX0 > TURNAROUND) ? CMAX0 : TURNAROUND;
  localparam int unsigned CNT_W = (CMAX < 2) ? 1 : $clog2(CMAX);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_START, S_RW, S_ADDR, S_TURN, S_WDATA, S_RDATA, S_HOLD, S_GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shift;
  logic             rw_q;
  logic             accept;
  logic             byte_end;
  logic             last_byte;
  logic [WIDTH-1:0] rx_next;
  logic             mosi_d;

  assign accept   = (state == S_IDLE) && Cmd_Valid && Cmd_Ready;
  assign byte_end = ((state == S_WDATA) || (state == S_RDATA)) && (cnt == BIT_LAST);
  assign rx_next  = {shift[WIDTH-2:0], MISO};

`ifdef SPI_MASTER_BURST_EN
  logic [LEN_W-1:0] byte_cnt;

  assign last_byte = (byte_cnt == '0);

  always_ff @(posedge SCLK) begin
    if (RST) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= Cmd_Len;
    end else if (byte_end && !last_byte) begin
      byte_cnt <= byte_cnt - LEN_W'(1);
    end
  end
`else
  logic unused_len;

  assign last_byte  = 1'b1;
  assign unused_len = ^Cmd_Len;
`endif

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shift     <= '0;
      rw_q      <= 1'b0;
      Cmd_Ready <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Tx_Pop    <= 1'b0;
      Rx_Valid  <= 1'b0;
      Rx_Data   <= '0;
    end else begin
      Done     <= 1'b0;
      Tx_Pop   <= 1'b0;
      Rx_Valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            rw_q      <= Cmd_RW;
            // The address waits in the shifter until the ADDR phase.
            shift     <= Cmd_Addr;
            cnt       <= '0;
            Cmd_Ready <= 1'b0;
            Busy      <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= S_START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_START: state <= S_RW;
        S_RW: begin
          cnt   <= '0;
          state <= S_ADDR;
        end
        S_ADDR: begin
          shift <= shift << 1;
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rw_q) begin
              state <= (TURNAROUND == 0) ? S_RDATA : S_TURN;
            end else begin
              // First write byte enters on the edge that begins its first bit.
              shift  <= Tx_Data;
              Tx_Pop <= 1'b1;
              state  <= S_WDATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_TURN: begin
          if (cnt == TURN_LAST) begin
            cnt   <= '0;
            state <= S_RDATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WDATA: begin
          shift <= shift << 1;
          if (byte_end) begin
            cnt <= '0;
            if (last_byte) begin
              state <= S_HOLD;
            end else begin
              shift  <= Tx_Data;
              Tx_Pop <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RDATA: begin
          shift <= rx_next;
          if (byte_end) begin
            cnt      <= '0;
            Rx_Data  <= rx_next;
            Rx_Valid <= 1'b1;
            if (last_byte) begin
              state <= S_HOLD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          Done  <= 1'b1;
          state <= S_GAP;
        end
        S_GAP: begin
          Busy      <= 1'b0;
          Cmd_Ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mosi_d = 1'b0;
    case (state)
      S_START:         mosi_d = 1'b1;
      S_RW:            mosi_d = rw_q;
      S_ADDR, S_WDATA: mosi_d = shift[WIDTH-1];
      default:         mosi_d = 1'b0;
    endcase
  end

  // Pin retiming: the pins follow the FSM state half a cycle later, so a
  // reset returns SS high at the first falling edge after the reset edge.
  always_ff @(negedge SCLK) begin
    SS   <= (state == S_IDLE) || (state == S_GAP);
    MOSI <= mosi_d;
  end

endmodule
